// File: rtl/aec_if.sv
// aec_if: character-in / result-out handshake bundle for the aec_param calculator.
interface aec_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    ascii_in;
  logic          out_valid;
  logic [DW-1:0] result;
  logic          err;

  modport master (output in_valid, ascii_in, input in_ready, out_valid, result, err);
  modport slave  (input in_valid, ascii_in, output in_ready, out_valid, result, err);
endinterface

// File: rtl/aec_param.sv
// aec_param: ASCII infix calculator -- token buffer, shunting-yard conversion, postfix evaluation.
// Optional feature: define AEC_DIV_EN to enable the `/` operator with a single-cycle divider.
module aec_param #(
  parameter int DW    = 16,
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  aec_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 4);

  typedef enum logic [2:0] {S_BUFFER, S_CONVERT, S_FLUSH, S_EVAL, S_DONE} state_e;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LP, OP_RP} op_e;
  typedef enum logic [2:0] {A_NONE, A_OPND, A_PUSH, A_POP, A_DISC, A_ERR} act_e;
  typedef struct packed {
    logic          is_op;
    op_e           op;
    logic [DW-1:0] val;
  } tok_t;

  state_e        state, state_next;
  tok_t          tok_buf [DEPTH];
  tok_t          pf_buf  [DEPTH];
  op_e           op_stk  [DEPTH];
  logic [DW-1:0] val_stk [DEPTH];
  logic [CW-1:0] tok_cnt, tok_rd, pf_cnt, pf_rd, op_sp, val_sp;
  logic [DW-1:0] acc, result_q, alu_a, alu_b, alu_y;
  logic          acc_vld, err_flag, out_valid_q, err_q;
  logic          is_digit, is_opch, is_eq, is_illegal, in_fire;
  logic [3:0]    digit;
  op_e           ch_op, top_op;
  logic          close_opnd, wr0_en, wr1_en, ovf, empty, eval_busy, div0, err_now, err_any;
  tok_t          wr0_tok, op_tok, cur_tok, pf_tok, pop_tok;
  logic [CW-1:0] tok_sum;
  logic [IW-1:0] top_idx, vsp_m1, vsp_m2;
  act_e          conv_act;

  function automatic logic is_hi(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    is_digit = 1'b0;
    is_opch  = 1'b0;
    is_eq    = 1'b0;
    digit    = '0;
    ch_op    = OP_ADD;
    if (bus.ascii_in >= "0" && bus.ascii_in <= "9") begin
      is_digit = 1'b1;
      digit    = 4'(bus.ascii_in - "0");
    end else if (bus.ascii_in >= "a" && bus.ascii_in <= "f") begin
      is_digit = 1'b1;
      digit    = 4'(bus.ascii_in - 8'h57);
    end else begin
      case (bus.ascii_in)
        "+": begin is_opch = 1'b1; ch_op = OP_ADD; end
        "-": begin is_opch = 1'b1; ch_op = OP_SUB; end
        "*": begin is_opch = 1'b1; ch_op = OP_MUL; end
        "(": begin is_opch = 1'b1; ch_op = OP_LP;  end
        ")": begin is_opch = 1'b1; ch_op = OP_RP;  end
        "=": is_eq = 1'b1;
`ifdef AEC_DIV_EN
        "/": begin is_opch = 1'b1; ch_op = OP_DIV; end
`endif
        default: ;
      endcase
    end
  end

  // A non-digit closes a pending operand, so one character can produce two tokens.
  assign is_illegal = !(is_digit || is_opch || is_eq);
  assign in_fire    = bus.in_valid && bus.in_ready;
  assign close_opnd = acc_vld && !is_digit;
  assign op_tok     = tok_t'{is_op: 1'b1, op: ch_op, val: '0};
  assign wr0_en     = close_opnd || is_opch;
  assign wr1_en     = close_opnd && is_opch;
  assign wr0_tok    = close_opnd ? tok_t'{is_op: 1'b0, op: OP_ADD, val: acc} : op_tok;
  assign tok_sum    = tok_cnt + CW'(wr0_en) + CW'(wr1_en);
  assign ovf        = tok_sum > CW'(DEPTH);
  assign empty      = is_eq && (tok_cnt == '0) && !acc_vld;

  assign cur_tok = tok_buf[tok_rd[IW-1:0]];
  assign top_idx = op_sp[IW-1:0] - IW'(1);
  assign top_op  = op_stk[top_idx];
  assign pop_tok = tok_t'{is_op: 1'b1, op: top_op, val: '0};

  always_comb begin
    conv_act = A_NONE;
    if (tok_rd != tok_cnt) begin
      if (!cur_tok.is_op)              conv_act = A_OPND;
      else if (cur_tok.op == OP_LP)    conv_act = A_PUSH;
      else if (cur_tok.op == OP_RP)    conv_act = (op_sp == '0)     ? A_ERR  :
                                                  (top_op == OP_LP) ? A_DISC : A_POP;
      else if (op_sp != '0 && top_op != OP_LP && (is_hi(top_op) || !is_hi(cur_tok.op)))
                                       conv_act = A_POP;
      else                             conv_act = A_PUSH;
    end
  end

  assign pf_tok    = pf_buf[pf_rd[IW-1:0]];
  assign eval_busy = pf_rd != pf_cnt;
  assign vsp_m1    = val_sp[IW-1:0] - IW'(1);
  assign vsp_m2    = val_sp[IW-1:0] - IW'(2);
  assign alu_a     = val_stk[vsp_m2];
  assign alu_b     = val_stk[vsp_m1];

  always_comb begin
    alu_y = '0;
    div0  = 1'b0;
    case (pf_tok.op)
      OP_ADD: alu_y = alu_a + alu_b;
      OP_SUB: alu_y = alu_a - alu_b;
      OP_MUL: alu_y = alu_a * alu_b;
`ifdef AEC_DIV_EN
      OP_DIV: begin
        div0  = (alu_b == '0);
        alu_y = div0 ? '0 : alu_a / alu_b;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    err_now = 1'b0;
    case (state)
      S_BUFFER:  err_now = in_fire && (is_illegal || ovf || empty);
      S_CONVERT: err_now = (conv_act == A_ERR);
      S_FLUSH:   err_now = (op_sp != '0) && (top_op == OP_LP);
      S_EVAL:    err_now = eval_busy ? (pf_tok.is_op && (val_sp < CW'(2) || div0))
                                     : (val_sp != CW'(1));
      default: ;
    endcase
  end
  assign err_any = err_flag || err_now;

  always_comb begin
    state_next = state;
    case (state)
      S_BUFFER:  if (in_fire && is_eq) state_next = err_any ? S_DONE : S_CONVERT;
      S_CONVERT: if (err_any) state_next = S_DONE; else if (tok_rd == tok_cnt) state_next = S_FLUSH;
      S_FLUSH:   if (err_any) state_next = S_DONE; else if (op_sp == '0) state_next = S_EVAL;
      S_EVAL:    if (err_any || !eval_busy) state_next = S_DONE;
      default:   state_next = S_BUFFER;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BUFFER;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_cnt <= '0; tok_rd <= '0; pf_cnt <= '0; pf_rd <= '0; op_sp <= '0; val_sp <= '0;
      acc <= '0; acc_vld <= 1'b0; err_flag <= 1'b0;
      out_valid_q <= 1'b0; err_q <= 1'b0; result_q <= '0;
    end else begin
      out_valid_q <= (state_next == S_DONE);
      if (state_next == S_DONE) begin
        result_q <= err_any ? '0 : val_stk[0];
        err_q    <= err_any;
      end
      if (err_now) err_flag <= 1'b1;
      case (state)
        S_BUFFER: if (in_fire) begin
          acc     <= is_digit ? ((acc << 4) | DW'(digit)) : '0;
          acc_vld <= is_digit;
          tok_cnt <= ovf ? CW'(DEPTH + 1) : tok_sum;
        end
        S_CONVERT: case (conv_act)
          A_OPND: begin pf_cnt <= pf_cnt + CW'(1); tok_rd <= tok_rd + CW'(1); end
          A_PUSH: begin op_sp  <= op_sp + CW'(1);  tok_rd <= tok_rd + CW'(1); end
          A_POP:  begin op_sp  <= op_sp - CW'(1);  pf_cnt <= pf_cnt + CW'(1); end
          A_DISC: begin op_sp  <= op_sp - CW'(1);  tok_rd <= tok_rd + CW'(1); end
          default: ;
        endcase
        S_FLUSH: if (op_sp != '0 && top_op != OP_LP) begin
          op_sp  <= op_sp - CW'(1);
          pf_cnt <= pf_cnt + CW'(1);
        end
        S_EVAL: if (eval_busy && !err_now) begin
          pf_rd  <= pf_rd + CW'(1);
          val_sp <= pf_tok.is_op ? val_sp - CW'(1) : val_sp + CW'(1);
        end
        default: begin
          tok_cnt <= '0; tok_rd <= '0; pf_cnt <= '0; pf_rd <= '0; op_sp <= '0; val_sp <= '0;
          acc <= '0; acc_vld <= 1'b0; err_flag <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the storage arrays are not reset; the cleared pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    case (state)
      S_BUFFER: if (in_fire) begin
        if (wr0_en && tok_cnt < CW'(DEPTH))
          tok_buf[tok_cnt[IW-1:0]] <= wr0_tok;
        if (wr1_en && (tok_cnt + CW'(1)) < CW'(DEPTH))
          tok_buf[tok_cnt[IW-1:0] + IW'(1)] <= op_tok;
      end
      S_CONVERT: begin
        if (conv_act == A_OPND) pf_buf[pf_cnt[IW-1:0]] <= cur_tok;
        if (conv_act == A_POP)  pf_buf[pf_cnt[IW-1:0]] <= pop_tok;
        if (conv_act == A_PUSH) op_stk[op_sp[IW-1:0]]  <= cur_tok.op;
      end
      S_FLUSH: if (op_sp != '0 && top_op != OP_LP) pf_buf[pf_cnt[IW-1:0]] <= pop_tok;
      S_EVAL: if (eval_busy && !err_now) begin
        if (pf_tok.is_op) val_stk[vsp_m2] <= alu_y;
        else              val_stk[val_sp[IW-1:0]] <= pf_tok.val;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state == S_BUFFER);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule
